// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC encodings for branch resolution and fetch/execute sequencing.
package kgp_risc_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_BR   = 3'b001,
      BR_BLTZ = 3'b010,
      BR_BZ   = 3'b011,
      BR_BNZ  = 3'b100,
      BR_BL   = 3'b101,
      BR_BCY  = 3'b110,
      BR_BNCY = 3'b111
   } br_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_EXEC  = 2'b10
   } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Resolves a KGP-RISC branch condition from the ALU sign flags and latched carry.
module branch_cond_eval
   import kgp_risc_pkg::*;
(
   input  logic [2:0] br_op,
   input  logic [1:0] alu_sign,
   input  logic       alu_cout,
   output logic       cond_taken,
   output logic       is_link
);

   always_comb begin
      cond_taken = 1'b0;
      is_link    = 1'b0;
      unique case (br_op)
         BR_NONE: cond_taken = 1'b0;
         BR_BR:   cond_taken = 1'b1;
         BR_BLTZ: cond_taken = alu_sign[0];
         BR_BZ:   cond_taken = alu_sign[1];
         BR_BNZ:  cond_taken = ~alu_sign[1];
         BR_BL: begin
            cond_taken = 1'b1;
            is_link    = 1'b1;
         end
         BR_BCY:  cond_taken = alu_cout;
         BR_BNCY: cond_taken = ~alu_cout;
         default: cond_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter owner: fetch handshake to imem, branch resolution at execute.
module branch_pc_unit
   import kgp_risc_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic              instr_done,
   input  logic [2:0]        br_op,
   input  logic [ADDR_W-1:0] br_target,
   input  logic [1:0]        alu_sign,
   input  logic              alu_cout,
   output logic [ADDR_W-1:0] pc,
   output logic              taken,
   output logic              link_we,
   output logic [ADDR_W-1:0] link_data
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   state_e            state;
   logic              cond_taken;
   logic              is_link;
   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] tgt_pc;
   logic [ADDR_W-1:0] next_pc;
   logic              unused_tgt_lsb;

   branch_cond_eval u_cond (
      .br_op      (br_op),
      .alu_sign   (alu_sign),
      .alu_cout   (alu_cout),
      .cond_taken (cond_taken),
      .is_link    (is_link)
   );

   // Targets are word aligned; the low bits of br_target carry no meaning.
   assign unused_tgt_lsb = ^br_target[1:0];
   assign seq_pc  = pc + STEP;
   assign tgt_pc  = {br_target[ADDR_W-1:2], 2'b00};
   assign next_pc = cond_taken ? tgt_pc : seq_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pc        <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         taken     <= 1'b0;
         link_we   <= 1'b0;
         link_data <= '0;
      end else begin
         taken   <= 1'b0;
         link_we <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (run) begin
                  state     <= ST_FETCH;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  state    <= ST_EXEC;
                  imem_req <= 1'b0;
               end
            end
            ST_EXEC: begin
               if (instr_done) begin
                  pc    <= next_pc;
                  taken <= cond_taken;
                  if (is_link) begin
                     link_we   <= 1'b1;
                     link_data <= seq_pc;
                  end
                  // Next fetch launches on this same edge so no idle bubble.
                  if (run) begin
                     state     <= ST_FETCH;
                     imem_req  <= 1'b1;
                     imem_addr <= next_pc;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
